// File: rtl/mem_pkg.sv
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared widths and FSM state type for the main memory block.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int ADDR_W      = 10;
  localparam int BLOCK_BYTES = 16;
  localparam int DATA_W      = 128;
  localparam int IDX_W       = 6;
  localparam int NUM_BLOCKS  = 64;

  typedef logic [DATA_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_if.sv
// ============================================================================
//  Module      : mem_if
//  Description : Cache-side block request/response bus plus debug byte peek.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  block_t            req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  block_t            resp_rdata;
  logic [ADDR_W-1:0] dbg_addr;
  logic [7:0]        dbg_byte;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, dbg_addr,
    input  req_ready, resp_valid, resp_rdata, dbg_byte
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, dbg_addr,
    output req_ready, resp_valid, resp_rdata, dbg_byte
  );

endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
//  Module      : mem_array
//  Description : 64 x 128-bit block store, sync write, sync block read,
//                combinational byte peek.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_array
  import mem_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [IDX_W-1:0]  wr_idx_i,
  input  wire block_t            wr_data_i,
  input  wire logic              re_i,
  input  wire logic [IDX_W-1:0]  rd_idx_i,
  output      block_t            rd_data_o,
  input  wire logic [ADDR_W-1:0] peek_addr_i,
  output      logic [7:0]        peek_byte_o
);

  block_t mem_q [NUM_BLOCKS];
  block_t rd_data_q;
  block_t w_peek_blk;

  // Storage is deliberately not reset: contents survive controller resets.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (re_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign w_peek_blk  = mem_q[peek_addr_i[ADDR_W-1:4]];
  assign peek_byte_o = w_peek_blk[{peek_addr_i[3:0], 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/main_memory_ctrl.sv
// ============================================================================
//  Module      : main_memory_ctrl
//  Description : Fixed-latency block memory serving cache fills/write-backs.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int BLOCK_BYTES = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mem_if.slave      bus
);

  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic [BLOCK_BYTES*8-1:0] resp_rdata_q;
  logic                     wr_q;
  logic [IDX_W-1:0]         idx_q;
  block_t                   wdata_q;

  logic                     w_accept;
  logic                     w_commit;
  block_t                   w_arr_rdata;

  assign w_accept = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
  // Write lands on the WAIT->RESP edge; an asserted reset on that edge blocks it.
  assign w_commit = rst_n && (state_q == ST_WAIT) && (cnt_q == 4'd0) && wr_q;

  mem_array u_mem_array (
    .clk         (clk),
    .we_i        (w_commit),
    .wr_idx_i    (idx_q),
    .wr_data_i   (wdata_q),
    .re_i        (w_accept && !bus.req_write),
    .rd_idx_i    (bus.req_addr[ADDR_W-1:4]),
    .rd_data_o   (w_arr_rdata),
    .peek_addr_i (bus.dbg_addr),
    .peek_byte_o (bus.dbg_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            wr_q        <= bus.req_write;
            idx_q       <= bus.req_addr[ADDR_W-1:4];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= c_CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            if (!wr_q) begin
              resp_rdata_q <= w_arr_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

`default_nettype wire
